// File: rtl/lut_pkg.sv
// Shared types and default sizes for the vector lookup pipeline.
package lut_pkg;

  localparam int unsigned LUT_N     = 8;
  localparam int unsigned LUT_W     = 32;
  localparam int unsigned LUT_LANES = 4;
  localparam int unsigned LUT_DEPTH = 256;

  typedef logic [LUT_N-1:0] lut_idx_t;
  typedef logic [LUT_W-1:0] lut_word_t;

  // Lane 0 sits in the least significant idx/oob slot.
  typedef struct packed {
    logic                             valid;
    lut_idx_t [LUT_LANES-1:0]         idx;
    logic     [LUT_LANES-1:0]         oob;
  } lut_stage_t;

endpackage

// File: rtl/lut_table_mem.sv
// DEPTH x W flop table: one write port, LANES registered read ports,
// read-before-write, cleared by synchronous reset.
module lut_table_mem
  import lut_pkg::*;
#(
  parameter int unsigned N     = LUT_N,
  parameter int unsigned W     = LUT_W,
  parameter int unsigned LANES = LUT_LANES,
  parameter int unsigned DEPTH = LUT_DEPTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_en_i,
  input  logic [N-1:0]         wr_addr_i,
  input  logic [W-1:0]         wr_data_i,
  input  logic                 rd_en_i,
  input  logic [LANES*N-1:0]   rd_addr_i,
  input  logic [LANES-1:0]     rd_zero_i,
  output logic [LANES*W-1:0]   rd_data_o
);

  localparam int unsigned AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [N:0]  DEPTH_L = (N+1)'(DEPTH);

  logic [W-1:0]       mem_q [DEPTH];
  logic [LANES*W-1:0] rd_data_q;
  logic               wr_hit;

  assign wr_hit = wr_en_i && ({1'b0, wr_addr_i} < DEPTH_L);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[AW'(i)] <= '0;
      end
    end else if (wr_hit) begin
      mem_q[AW'(wr_addr_i)] <= wr_data_i;
    end
  end

  // Out-of-range lanes are forced to zero rather than indexing past the array.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_q <= '0;
    end else if (rd_en_i) begin
      for (int unsigned l = 0; l < LANES; l++) begin
        rd_data_q[l*W +: W] <= rd_zero_i[l] ? '0 : mem_q[AW'(rd_addr_i[l*N +: N])];
      end
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/lut_vec_pipe.sv
// Two-stage multi-lane table lookup with valid/ready on both sides.
// Optional in-range lookup counter enabled by LUT_VEC_PIPE_CNT_EN.
module lut_vec_pipe
  import lut_pkg::*;
#(
  parameter int unsigned N     = LUT_N,
  parameter int unsigned W     = LUT_W,
  parameter int unsigned LANES = LUT_LANES,
  parameter int unsigned DEPTH = LUT_DEPTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_en,
  input  logic [N-1:0]         wr_addr,
  input  logic [W-1:0]         wr_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [LANES*N-1:0]   in_idx,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [LANES*W-1:0]   out_data,
  output logic [LANES-1:0]     out_oob,
  output logic [31:0]          lookup_cnt
);

  localparam logic [N:0] DEPTH_L = (N+1)'(DEPTH);

  // Stage register layout comes from lut_stage_t, so N and LANES track the package.
  lut_stage_t         s1_q, s1_d;
  logic               s2_valid_q;
  logic [LANES-1:0]   out_oob_q;
  logic               adv;

  assign adv      = !s2_valid_q || out_ready;
  assign in_ready = adv;

  always_comb begin
    s1_d = s1_q;
    if (adv) begin
      s1_d.valid = in_valid;
      for (int unsigned l = 0; l < LANES; l++) begin
        s1_d.idx[l] = in_idx[l*N +: N];
        s1_d.oob[l] = ({1'b0, in_idx[l*N +: N]} >= DEPTH_L);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= '0;
    end else begin
      s1_q <= s1_d;
    end
  end

  // S2 control; its data half lives in the table's registered read ports.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid_q <= 1'b0;
      out_oob_q  <= '0;
    end else if (adv) begin
      s2_valid_q <= s1_q.valid;
      out_oob_q  <= s1_q.oob;
    end
  end

  lut_table_mem #(
    .N     (N),
    .W     (W),
    .LANES (LANES),
    .DEPTH (DEPTH)
  ) u_table (
    .clk       (clk),
    .rst       (rst),
    .wr_en_i   (wr_en),
    .wr_addr_i (wr_addr),
    .wr_data_i (wr_data),
    .rd_en_i   (adv),
    .rd_addr_i (s1_q.idx),
    .rd_zero_i (s1_q.oob),
    .rd_data_o (out_data)
  );

  assign out_valid = s2_valid_q;
  assign out_oob   = out_oob_q;

`ifdef LUT_VEC_PIPE_CNT_EN
  logic [31:0] lookup_cnt_q, lookup_cnt_d;
  logic [31:0] hits;

  // Counts in-range lanes as a vector moves S1 -> S2; wraps naturally.
  always_comb begin
    hits = '0;
    for (int unsigned l = 0; l < LANES; l++) begin
      hits = hits + 32'(!s1_q.oob[l]);
    end
    lookup_cnt_d = lookup_cnt_q;
    if (s1_q.valid && adv) begin
      lookup_cnt_d = lookup_cnt_q + hits;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lookup_cnt_q <= '0;
    end else begin
      lookup_cnt_q <= lookup_cnt_d;
    end
  end

  assign lookup_cnt = lookup_cnt_q;
`else
  assign lookup_cnt = '0;
`endif

endmodule

// File: tb/tb_lut_vec_pipe.sv
// Randomised and directed bench for lut_vec_pipe against a table/queue model.
module tb_lut_vec_pipe;

  localparam int unsigned N     = 8;
  localparam int unsigned W     = 32;
  localparam int unsigned LANES = 4;
  localparam int unsigned DEPTH = 200;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 wr_en;
  logic [N-1:0]         wr_addr;
  logic [W-1:0]         wr_data;
  logic                 in_valid;
  logic                 in_ready;
  logic [LANES*N-1:0]   in_idx;
  logic                 out_valid;
  logic                 out_ready;
  logic [LANES*W-1:0]   out_data;
  logic [LANES-1:0]     out_oob;
  logic [31:0]          lookup_cnt;

  lut_vec_pipe #(.N(N), .W(W), .LANES(LANES), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_idx     (in_idx),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_oob    (out_oob),
    .lookup_cnt (lookup_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [127:0] d;
    logic [3:0]   o;
  } exp_t;

  int           checks = 0;
  int           errors = 0;
  logic [31:0]  ref_tbl [256];
  exp_t         exp_q [$];
  bit           prev_stall;
  logic [127:0] prev_data;
  logic [3:0]   prev_oob;
  int           n_out;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // Expected result of a lookup against the current reference table.
  function automatic exp_t model(input logic [31:0] idx);
    exp_t e;
    e = '0;
    for (int l = 0; l < 4; l++) begin
      int unsigned a;
      a = 32'(idx[l*8 +: 8]);
      if (a < DEPTH) e.d[l*32 +: 32] = ref_tbl[a];
      else           e.o[l] = 1'b1;
    end
    return e;
  endfunction

  // Sample one cycle's handshakes, update the scoreboard, advance to next negedge.
  task automatic step(output bit acc);
    exp_t e;
    acc = 1'b0;
    #1;
    if (rst) begin
      exp_q.delete();
      foreach (ref_tbl[i]) ref_tbl[i] = '0;
      prev_stall = 1'b0;
    end else begin
      check("in_ready", 128'(in_ready), 128'(!(out_valid && !out_ready)));
      if (prev_stall) begin
        check("hold_data", out_data, prev_data);
        check("hold_oob", 128'(out_oob), 128'(prev_oob));
      end
      if (out_valid && out_ready) begin
        check("out_expected", 128'(exp_q.size() != 0), 128'(1));
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("out_data", out_data, e.d);
          check("out_oob", 128'(out_oob), 128'(e.o));
          n_out++;
        end
      end
      if (wr_en && (32'(wr_addr) < DEPTH)) ref_tbl[wr_addr] = wr_data;
      if (in_valid && in_ready) begin
        acc = 1'b1;
        exp_q.push_back(model(in_idx));
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_oob   = out_oob;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_step();
    bit a;
    step(a);
  endtask

  task automatic tbl_write(input int unsigned addr, input logic [31:0] data);
    wr_en   = 1'b1;
    wr_addr = 8'(addr);
    wr_data = data;
    idle_step();
    wr_en   = 1'b0;
  endtask

  initial begin
    bit acc;
    int k;
    int cyc;
    int start;
    bit pat [4];
    pat = '{1'b1, 1'b0, 1'b0, 1'b1};

    rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    in_valid = 1'b0; in_idx = '0; out_ready = 1'b1;
    prev_stall = 1'b0; prev_data = '0; prev_oob = '0; n_out = 0;
    foreach (ref_tbl[i]) ref_tbl[i] = '0;

    @(negedge clk);
    idle_step();
    idle_step();
    rst = 1'b0;
    check("rst_out_valid", 128'(out_valid), 128'(0));
    check("rst_out_data", out_data, 128'(0));
    check("rst_out_oob", 128'(out_oob), 128'(0));
    check("rst_in_ready", 128'(in_ready), 128'(1));
    check("rst_cnt", 128'(lookup_cnt), 128'(0));

    // Basic lookup and two-cycle latency
    tbl_write(1, 32'h3F576AA4);
    tbl_write(2, 32'h3F68C7B7);
    in_valid = 1'b1;
    in_idx   = {8'd2, 8'd1, 8'd0, 8'd1};
    step(acc);
    check("basic_acc", 128'(acc), 128'(1));
    in_valid = 1'b0;
    check("lat1_valid", 128'(out_valid), 128'(0));
    idle_step();
    check("lat2_valid", 128'(out_valid), 128'(1));
    check("basic_data", out_data, {32'h3F68C7B7, 32'h3F576AA4, 32'h0, 32'h3F576AA4});
    check("basic_oob", 128'(out_oob), 128'(0));
    idle_step();

    // Out-of-range lanes, including an ignored write beyond DEPTH
    tbl_write(199, 32'hAA);
    tbl_write(0, 32'h55);
    tbl_write(210, 32'hDEAD);
    in_valid = 1'b1;
    in_idx   = {8'd0, 8'd250, 8'd200, 8'd199};
    step(acc);
    in_valid = 1'b0;
    idle_step();
    check("oob_data", out_data, {32'h55, 32'h0, 32'h0, 32'hAA});
    check("oob_flags", 128'(out_oob), 128'(4'b0110));
    idle_step();

    // Write/read collision returns the old value
    tbl_write(5, 32'h11);
    in_valid = 1'b1;
    in_idx   = {4{8'd5}};
    step(acc);
    in_valid = 1'b0;
    wr_en = 1'b1; wr_addr = 8'd5; wr_data = 32'h22;
    idle_step();
    wr_en = 1'b0;
    check("coll_valid", 128'(out_valid), 128'(1));
    check("coll_old", out_data, {4{32'h11}});
    in_valid = 1'b1;
    step(acc);
    in_valid = 1'b0;
    idle_step();
    check("coll_new", out_data, {4{32'h22}});
    idle_step();

    // Backpressure with out_ready toggling 1,0,0,1
    k = 0; cyc = 0; start = n_out;
    while ((k < 4 || exp_q.size() != 0) && cyc < 40) begin
      out_ready = pat[cyc % 4];
      in_valid  = (k < 4);
      in_idx    = {4{8'(k)}};
      step(acc);
      if (acc) k++;
      cyc++;
    end
    out_ready = 1'b1;
    in_valid  = 1'b0;
    check("bp_timeout", 128'(cyc < 40), 128'(1));
    check("bp_count", 128'(n_out - start), 128'(4));

    // Reset with two vectors in flight
    tbl_write(7, 32'h77);
    in_valid = 1'b1;
    in_idx   = {4{8'd7}};
    step(acc);
    in_idx   = {4{8'd3}};
    step(acc);
    in_valid = 1'b0;
    rst = 1'b1;
    idle_step();
    rst = 1'b0;
    check("mid_rst_valid", 128'(out_valid), 128'(0));
    check("mid_rst_ready", 128'(in_ready), 128'(1));
    in_valid = 1'b1;
    in_idx   = {4{8'd7}};
    step(acc);
    in_valid = 1'b0;
    idle_step();
    check("mid_rst_lkp_v", 128'(out_valid), 128'(1));
    check("mid_rst_lkp_d", out_data, 128'(0));
    idle_step();

`ifdef LUT_VEC_PIPE_CNT_EN
    rst = 1'b1;
    idle_step();
    rst = 1'b0;
    in_idx = {8'd3, 8'd2, 8'd250, 8'd1};
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      step(acc);
    end
    in_valid = 1'b0;
    idle_step();
    idle_step();
    check("cnt_nine", 128'(lookup_cnt), 128'(9));
    force dut.lookup_cnt_q = 32'hFFFF_FFFE;
    #1;
    release dut.lookup_cnt_q;
    in_valid = 1'b1;
    in_idx   = {4{8'd1}};
    step(acc);
    in_valid = 1'b0;
    idle_step();
    check("cnt_wrap", 128'(lookup_cnt), 128'(2));
    idle_step();
`else
    check("cnt_tied", 128'(lookup_cnt), 128'(0));
`endif

    // Random table load, then random traffic with random backpressure
    for (int i = 0; i < 60; i++) begin
      tbl_write($urandom_range(0, 255), $urandom);
    end
    for (int c = 0; c < 300; c++) begin
      in_valid  = (($urandom % 4) != 0);
      in_idx    = $urandom;
      out_ready = (($urandom % 3) != 0);
      step(acc);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 10) begin
      idle_step();
      cyc++;
    end
    check("drain_empty", 128'(exp_q.size()), 128'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lut_vec_pipe.md
Name: lut_vec_pipe

Overview:
- Multi-lane, pipelined lookup unit for the vector datapath: each lane maps an N-bit index to a W-bit word, such as a single-precision function sample.
- The table is writable at run time, so software can load sin, exp or other tables.
- Sits between the vector register read stage and the vector ALU writeback, using a valid/ready handshake on both sides.

Parameters:
- N, 8, index width per lane.
- W, 32, table word width.
- LANES, 4, lanes per vector.
- DEPTH, 256, table entries; must satisfy 1 <= DEPTH <= 2**N.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active high
- wr_en  in  1  table write strobe
- wr_addr  in  N  table write address
- wr_data  in  W  table write data
- in_valid  in  1  input vector valid
- in_ready  out  1  unit can accept an input vector
- in_idx  in  LANES*N  lane indices; lane i occupies bits [i*N +: N]
- out_valid  out  1  result vector valid
- out_ready  in  1  consumer accepts result
- out_data  out  LANES*W  lane results; lane i occupies bits [i*W +: W]
- out_oob  out  LANES  per-lane flag: index >= DEPTH
- lookup_cnt  out  32  in-range lookup counter (optional feature)

Behaviour:
- Reset and clock:
  - One clock; reset is synchronous and active-high.
  - While rst=1, all table entries clear to 0, and s1_valid, s2_valid, out_valid, out_data, out_oob and lookup_cnt clear to 0.
- Pipeline:
  - S1 registers in_idx and computes oob[i] = (idx_i >= DEPTH).
  - S2 registers the table read: data_i = oob[i] ? 0 : table[idx_i].
  - out_data, out_oob and out_valid come from S2.
  - Latency is exactly 2 cycles from an accepted input to out_valid, with no stall.
- Handshake:
  - adv = !s2_valid | out_ready.
  - in_ready = adv; it is a combinational function of s2_valid and out_ready only, never of in_valid.
  - The input is accepted when in_valid & in_ready.
  - When adv=1: S2 <= S1 contents, S1 <= input, and s1_valid <= in_valid.
  - When adv=0: both stages hold their contents unchanged.
  - Full throughput is one vector per cycle when out_ready stays high.
- Output stability: out_data and out_oob must not change while out_valid & !out_ready.
- Writes:
  - Writes are accepted every cycle regardless of stall; wr_addr >= DEPTH is ignored.
  - A write and a read of the same address in the same cycle: the read in S2 returns the OLD value, and the new value is visible from the next cycle.
  - Data already held in S2 is not altered by later writes.
- Multiple lanes may read the same address in the same cycle; all receive the same value.
- Reset mid-operation: in-flight vectors are discarded and out_valid drops the cycle after rst is sampled. No partial vector is ever presented.
- Unwritten entries return 0.

Optional Feature:
- Macro: LUT_VEC_PIPE_CNT_EN.
- When defined:
  - lookup_cnt increments by the number of in-range lanes of each vector as it moves S1->S2, i.e. s1_valid & adv.
  - It wraps modulo 2**32 and clears on rst.
- When undefined: lookup_cnt is tied to 0 and the counter logic is absent.

Decomposition:
- Shared package lut_pkg holds:
  - default constants LUT_N=8, LUT_W=32, LUT_LANES=4, LUT_DEPTH=256;
  - typedef lut_idx_t (logic [N-1:0]);
  - typedef lut_word_t (logic [W-1:0]);
  - the stage struct lut_stage_t {valid, idx[LANES], oob[LANES]}.
- One natural sub-module: lut_table_mem.
  - DEPTH x W flop array, one write port, LANES registered read ports.
  - Read-before-write semantics; clears on rst.
- lut_vec_pipe instantiates the table once and holds the handshake and stage logic.

Test Plan:
- Basic lookup: after reset, write addr 1 = 0x3F576AA4 and addr 2 = 0x3F68C7B7; drive in_idx lanes {1,0,1,2} with out_ready=1. Two cycles later expect out_valid=1, out_data {0x3F576AA4, 0, 0x3F576AA4, 0x3F68C7B7}, out_oob=0.
- Backpressure: stream 4 vectors with idx=k in all lanes (k=0..3) while out_ready toggles 1,0,0,1,... Expect all 4 outputs in order, out_data stable while stalled, no loss or duplication, and in_ready=0 exactly when s2_valid & !out_ready.
- Out of range: with DEPTH=200, use lanes {199,200,250,0}, where table[199]=0xAA and table[0]=0x55. Expect out_data {0xAA,0,0,0x55} and out_oob=4'b0110.
- Write/read collision: table[5]=0x11; in one cycle write table[5]=0x22 while S2 reads idx 5, expecting 0x11. A following lookup of idx 5 returns 0x22.
- Reset mid-stream: with 2 vectors in flight, assert rst for 1 cycle. Expect out_valid=0 and in_ready=1 the next cycle, and a lookup of a previously written address returns 0.
- Counter (LUT_VEC_PIPE_CNT_EN, DEPTH=200): 3 vectors of {1,250,2,3} give lookup_cnt=9. Preloading the counter with 0xFFFFFFFE via force, then one full in-range vector, gives 2.
